// File: rtl/add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_pkg
//  Purpose  : Shared types and constants for the byte-serial add/subtract
//             sequencer: FSM state encoding, byte width and index sizing.
//  Revision : 1.0  initial release
// ============================================================================
package add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Byte index width for an NBYTES-deep buffer (never narrower than 1 bit).
    function automatic int idx_w(input int nbytes);
        return (nbytes < 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : add_sequencer_if
//  Purpose  : Byte handshake bundle between the pin-level byte interface and
//             the add/subtract sequencer.
//  Signals  : start, sub          - operation request and mode
//             in_valid/in_ready   - operand byte pair handshake (op_a, op_b)
//             out_valid/out_ready - result byte handshake (out_data)
//             carry_out, busy     - final carry/no-borrow, non-idle flag
//  Modports : master - drives requests/operands, consumes results
//             slave  - the sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface add_sequencer_if;
    import add_pkg::*;

    logic              start;
    logic              sub;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] op_a;
    logic [BYTE_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;
    logic              carry_out;
    logic              busy;

    modport master (
        output start, sub, in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, out_data, carry_out, busy
    );

    modport slave (
        input  start, sub, in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, out_data, carry_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/add_sequencer_byte_adder.sv
`default_nettype none
// ============================================================================
//  Module   : byte_adder
//  Purpose  : Combinational 8-bit adder slice with optional B inversion, used
//             for both add (inv_b=0) and two's-complement subtract (inv_b=1,
//             cin seeded with 1 on the first byte).
//  Ports    : a, b   in  operand bytes
//             cin    in  carry in
//             inv_b  in  invert b before adding
//             sum    out result byte
//             cout   out carry out
//  Revision : 1.0  initial release
// ============================================================================
module byte_adder
    import add_pkg::*;
(
    input  wire logic [BYTE_W-1:0] a,
    input  wire logic [BYTE_W-1:0] b,
    input  wire logic              cin,
    input  wire logic              inv_b,
    output logic      [BYTE_W-1:0] sum,
    output logic                   cout
);

    logic [BYTE_W-1:0] w_b_eff;

    assign w_b_eff     = inv_b ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{BYTE_W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : add_sequencer
//  Purpose  : Byte-serial multi-byte add/subtract controller. Collects NBYTES
//             operand byte pairs LSB-first, runs them through one shared
//             8-bit adder with carry propagation, then streams the result
//             bytes out LSB-first.
//  Ports    : clk    in  system clock
//             rst_n  in  asynchronous active-low reset
//             ena    in  clock enable, low freezes all state
//             bus    add_sequencer_if.slave handshake bundle
//  Params   : NBYTES operand width in bytes (2..8)
//  Revision : 1.0  initial release
// ============================================================================
module add_sequencer
    import add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    add_sequencer_if.slave  bus
);

    localparam int               c_idx_w    = idx_w(NBYTES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBYTES - 1);

    state_e              state_q, state_d;
    logic [c_idx_w-1:0]  idx_q, idx_d;
    logic                sub_q, sub_d;
    logic                c_q, c_d;          // running carry between bytes
    logic                carry_q, carry_d;  // published final carry
    logic [BYTE_W-1:0]   a_buf_q   [NBYTES];
    logic [BYTE_W-1:0]   a_buf_d   [NBYTES];
    logic [BYTE_W-1:0]   b_buf_q   [NBYTES];
    logic [BYTE_W-1:0]   b_buf_d   [NBYTES];
    logic [BYTE_W-1:0]   res_buf_q [NBYTES];
    logic [BYTE_W-1:0]   res_buf_d [NBYTES];

    logic [BYTE_W-1:0]   w_sum;
    logic                w_cout;
    logic                w_last;

    assign w_last = (idx_q == c_last_idx);

    byte_adder u_adder (
        .a     (a_buf_q[idx_q]),
        .b     (b_buf_q[idx_q]),
        .cin   (c_q),
        .inv_b (sub_q),
        .sum   (w_sum),
        .cout  (w_cout)
    );

    // Outputs come only from registers and state decode; no handshake input
    // reaches an output combinationally.
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == OUT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = res_buf_q[idx_q];
    assign bus.carry_out = carry_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sub_d     = sub_q;
        c_d       = c_q;
        carry_d   = carry_q;
        a_buf_d   = a_buf_q;
        b_buf_d   = b_buf_q;
        res_buf_d = res_buf_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sub_d   = bus.sub;
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        a_buf_d[idx_q] = bus.op_a;
                        b_buf_d[idx_q] = bus.op_b;
                        if (w_last) begin
                            idx_d   = '0;
                            // Subtract is A + ~B + 1: seed the carry with sub.
                            c_d     = sub_q;
                            state_d = ADD;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ADD: begin
                    res_buf_d[idx_q] = w_sum;
                    c_d              = w_cout;
                    if (w_last) begin
                        carry_d = w_cout;
                        idx_d   = '0;
                        state_d = OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (w_last) begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                a_buf_q[i]   <= '0;
                b_buf_q[i]   <= '0;
                res_buf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sub_q     <= sub_d;
            c_q       <= c_d;
            carry_q   <= carry_d;
            a_buf_q   <= a_buf_d;
            b_buf_q   <= b_buf_d;
            res_buf_q <= res_buf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sequencer
//  Purpose  : Self-checking bench for add_sequencer (NBYTES=4). Stimulus
//             pushes expected result bytes into a scoreboard queue; a monitor
//             pops and compares on every result handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         carry;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ena;
    int   cyc;
    int   checks;
    int   errors;
    int   rdy_mode;
    exp_t exp_q[$];

    add_sequencer_if bus ();

    add_sequencer #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Result consumer: always ready, random, or a 3-cycle stall on byte 1.
    initial begin
        int hs;
        int stalls;
        hs     = 0;
        stalls = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) hs++;
            if (!bus.busy) begin
                hs     = 0;
                stalls = 0;
            end
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.out_valid && hs == 1 && stalls < 3) begin
                        bus.out_ready = 1'b0;
                        stalls++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop on each result handshake, plus hold checks.
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        exp_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", bus.out_valid, 1'b1);
                    chk("hold_data", bus.out_data, pd);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        if (e.last) chk("carry_out", bus.carry_out, e.carry);
                    end
                end
                pv = bus.out_valid;
                pr = bus.out_ready;
                pd = bus.out_data;
            end
        end
    end

    // Reference: plain wide arithmetic; carry means "no borrow" for subtract.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output logic [W-1:0] res, output bit carry);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned full;
        ua = longint'(a);
        ub = longint'(b);
        if (s) begin
            res   = W'(ua - ub);
            carry = (ua >= ub);
        end else begin
            full  = ua + ub;
            res   = W'(full);
            carry = (full >= (64'd1 << W));
        end
    endtask

    // gap: 0 = in_valid every cycle, 1 = idle cycle before each byte,
    // 2 = random. exp_load / exp_lat of 0 skip those timing checks.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input int gap, input bit junk, input bit ena_pause,
                          input int exp_load, input int exp_lat);
        logic [W-1:0] res;
        bit           carry;
        int           k;
        int           lc;
        int           guard;
        int           t0;
        bit           phase;
        bit           paused;
        bit           v;
        exp_t         e;

        model(a, b, s, res, carry);
        for (int i = 0; i < NB; i++) begin
            e.data  = res[8*i +: 8];
            e.last  = (i == NB - 1);
            e.carry = carry;
            exp_q.push_back(e);
        end

        bus.start = 1'b1;
        bus.sub   = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0        = cyc;

        k      = 0;
        lc     = 0;
        guard  = 0;
        phase  = 1'b0;
        paused = 1'b0;
        while (k < NB && guard < 200) begin
            if (ena_pause && k == 2 && !paused) begin
                paused  = 1'b1;
                ena     = 1'b0;
                repeat (5) begin
                    bus.in_valid = 1'b1;
                    bus.op_a     = 8'($urandom);
                    bus.op_b     = 8'($urandom);
                    @(negedge clk);
                    chk("ena_freeze_ready", bus.in_ready, 1'b1);
                    chk("ena_freeze_valid", bus.out_valid, 1'b0);
                    @(posedge clk);
                    #1;
                end
                ena = 1'b1;
            end
            case (gap)
                0:       v = 1'b1;
                1:       v = phase;
                default: v = 1'($urandom_range(0, 1));
            endcase
            phase        = ~phase;
            bus.in_valid = v;
            bus.op_a     = a[8*k +: 8];
            bus.op_b     = b[8*k +: 8];
            @(negedge clk);
            if (bus.in_ready) lc++;
            if (v && bus.in_ready) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("load_done", k, NB);
        if (exp_load > 0) chk("load_cycles", lc, exp_load);

        guard = 0;
        while (bus.busy && guard < 500) begin
            if (junk) begin
                bus.start    = bus.in_ready ? 1'b0 : 1'($urandom_range(0, 1));
                bus.in_valid = bus.out_valid ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.op_a     = 8'($urandom);
                bus.op_b     = 8'($urandom);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("idle_reached", bus.busy, 1'b0);
        chk("sb_drained", exp_q.size(), 0);
        if (exp_lat > 0) chk("start_to_idle", 1 + cyc - t0, exp_lat);
        repeat (2) @(posedge clk);
        #1;
        chk("carry_hold_idle", bus.carry_out, carry);
        chk("idle_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic reset_mid_add(input bit prev_carry);
        int addc;
        int guard;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = 8'($urandom);
            bus.op_b     = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        addc  = 0;
        guard = 0;
        while (addc < 2 && guard < 20) begin
            @(negedge clk);
            if (bus.busy && !bus.in_ready && !bus.out_valid) addc++;
            guard++;
        end
        chk("reached_add2", addc, 2);
        chk("carry_before_reset", bus.carry_out, prev_carry);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_carry", bus.carry_out, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rdy_mode      = 0;
        rst_n         = 1'b0;
        ena           = 1'b1;
        bus.start     = 1'b0;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_data", bus.out_data, 8'h00);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_carry", bus.carry_out, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with exact latency: 1 + 3*NB cycles from start to IDLE.
        run_op(32'h01020304, 32'h10203040, 1'b0, 0, 1'b0, 1'b0, NB, 1 + 3 * NB);
        // Overflow wraps to zero with carry.
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0, NB, 1 + 3 * NB);
        // Reset during ADD cycle 2 while carry_out still holds the overflow.
        reset_mid_add(1'b1);
        run_op(32'h01020304, 32'h10203040, 1'b0, 0, 1'b0, 1'b0, NB, 1 + 3 * NB);
        // Subtract, both orders.
        run_op(32'h00000005, 32'h00000003, 1'b1, 0, 1'b0, 1'b0, NB, 1 + 3 * NB);
        run_op(32'h00000003, 32'h00000005, 1'b1, 0, 1'b0, 1'b0, NB, 1 + 3 * NB);
        // in_valid gaps: every byte preceded by an idle cycle doubles LOAD.
        run_op(32'h01020304, 32'h10203040, 1'b0, 1, 1'b0, 1'b0, 2 * NB, 0);
        // Consumer stalls three cycles on byte 1 (0x33).
        rdy_mode = 2;
        run_op(32'h01020304, 32'h10203040, 1'b0, 0, 1'b0, 1'b0, NB, 0);
        // Stray start / in_valid outside their states.
        rdy_mode = 1;
        run_op(32'h01020304, 32'h10203040, 1'b0, 0, 1'b1, 1'b0, NB, 0);
        // Clock enable held low mid-LOAD.
        rdy_mode = 0;
        run_op(32'hDEADBEEF, 32'h12345678, 1'b1, 0, 1'b0, 1'b1, 0, 0);

        // Randomized traffic.
        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 2,
                   1'($urandom_range(0, 1)), 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/add_sequencer.md
# add_sequencer

Byte-serial multi-byte add/subtract controller that time-shares a single 8-bit adder across NBYTES operand bytes. Sits between the pin-level byte interface (ui_in/uio_in/uo_out) and the adder datapath in the tt_um top. It collects operand bytes, sequences the adder LSB-first with carry propagation, and streams result bytes back out under a valid/ready handshake.

## Interface

Parameters:
- NBYTES, 4, operand width in bytes (2..8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; low freezes all state
- start  in  1  begin new operation (sampled in IDLE only)
- sub  in  1  0 = A+B, 1 = A-B; latched with start
- in_valid  in  1  operand byte pair valid
- in_ready  out  1  block accepts operand byte pair
- op_a  in  8  operand A byte, LSB-first
- op_b  in  8  operand B byte, LSB-first
- out_valid  out  1  result byte valid
- out_ready  in  1  consumer accepts result byte
- out_data  out  8  result byte, LSB-first
- carry_out  out  1  final carry (sub: 1 = no borrow)
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, LOAD, ADD, OUT.
- IDLE: start=1 -> latch sub, clear byte index, go LOAD. carry_out holds the previous result.
- LOAD: in_ready=1. On in_valid&&in_ready, store op_a into a_buf[idx] and op_b into b_buf[idx], then idx++. Acceptance of byte NBYTES-1 -> idx=0, go ADD.
- ADD: one byte per cycle. sum9 = a_buf[idx] + (sub ? ~b_buf[idx] : b_buf[idx]) + c.
  - Carry c is initialised to sub at entry.
  - res_buf[idx] = sum9[7:0]; c = sum9[8].
  - After idx=NBYTES-1 -> carry_out=c, idx=0, go OUT.
- OUT: out_valid=1, out_data=res_buf[idx]. On out_ready, idx++. Acceptance of byte NBYTES-1 -> go IDLE.
- All arithmetic is modulo 2^(8*NBYTES). The adder is a single 9-bit result, computed combinationally from the indexed bytes.
- start outside IDLE: ignored. in_valid outside LOAD: ignored, with no storage.
- ena=0: no state, counter, or buffer updates. Outputs hold their values.
- Reset (asserted at any time, including mid-operation): state=IDLE, idx=0, c=0, carry_out=0, buffers cleared. Reset values: in_ready=0, out_valid=0, out_data=0, busy=0.

## Timing

- start sampled at edge T -> LOAD from T+1. in_ready is asserted combinationally from state.
- LOAD takes a minimum of NBYTES cycles and stretches with in_valid gaps.
- ADD takes exactly NBYTES cycles. No handshake stalls ADD.
- out_valid is first high on the cycle after the last ADD cycle.
- Minimum start-to-IDLE time: 1 + 3*NBYTES cycles (1 + NBYTES LOAD + NBYTES ADD + NBYTES OUT, minus the overlap of the start cycle).
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- carry_out updates on the final ADD edge. It is valid from the first OUT cycle until the next final ADD.
- All outputs are driven from registers or from the state decode. There is no combinational path from in_valid or out_ready to any output.

## Structure

- Shared package add_pkg holds:
  - state enum (IDLE, LOAD, ADD, OUT)
  - BYTE_W=8
  - function idx_w(NBYTES) = $clog2(NBYTES)
- Sub-module byte_adder: purely combinational. Inputs a[7:0], b[7:0], cin, inv_b. Outputs sum[7:0], cout. This keeps the adder datapath swappable and independently testable.
- The remainder (FSM, index counter, a/b/res buffers) lives in add_sequencer. The tt_um top maps pins onto its ports.

## Test plan

- Basic add, NBYTES=4: A=0x01020304, B=0x10203040, out_ready=1 -> out_data 0x44,0x33,0x22,0x11; carry_out=0; busy drops 13 cycles after start.
- Overflow: A=0xFFFFFFFF, B=0x00000001 -> out_data 0x00,0x00,0x00,0x00; carry_out=1.
- Subtract: sub=1, A=0x00000005, B=0x00000003 -> 0x02,0x00,0x00,0x00, carry_out=1. Swapped operands (A=3, B=5) -> 0xFE,0xFF,0xFF,0xFF, carry_out=0.
- Handshake stalls: in_valid toggling 1,0,1,0 in LOAD extends LOAD to 8 cycles with the correct result. out_ready low for 3 cycles on byte 1 -> out_data holds 0x33 and out_valid stays 1.
- Ignored events: start pulsed during ADD and OUT, and in_valid during OUT -> no state change; the result is unchanged.
- Reset mid-ADD: assert rst_n=0 on ADD cycle 2 -> next cycle busy=0, out_valid=0, carry_out=0. A subsequent full operation produces the correct result. Also check ena=0 for 5 cycles mid-LOAD -> state and idx frozen.
